// File: rtl/l2_arb_pkg.sv
// l2_arb_pkg
//   Shared constants for the parametrised L2 input arbiter: channel index
//   names, default parameter values, and width helpers used to size the
//   per-channel age counters and the MSHR credit counter.
package l2_arb_pkg;

   // Channel indices; a lower index means higher fixed priority.
   localparam int CH_FENCE   = 0;
   localparam int CH_RSP     = 1;
   localparam int CH_FWD     = 2;
   localparam int CH_ONGOING = 3;
   localparam int CH_CPU     = 4;

   localparam int N_CH_DEF         = 5;
   localparam int MSHR_DEPTH_DEF   = 4;
   localparam int STARVE_LIMIT_DEF = 7;

   // Channels that allocate an MSHR when granted (rsp and cpu_req).
   localparam logic [N_CH_DEF-1:0] CREDIT_MASK_DEF = 5'b10010;

   function automatic int age_w(input int limit);
      return $clog2(limit + 1);
   endfunction

   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   localparam int AGE_W = age_w(STARVE_LIMIT_DEF);
   localparam int CNT_W = cnt_w(MSHR_DEPTH_DEF);

endpackage

// File: rtl/l2_input_arbiter_param_if.sv
// l2_input_arbiter_param_if
//   Request-side bundle between the L2 input interfaces and the arbiter.
//   Ports: decode_en, req_valid[N_CH], req_elig[N_CH],
//          req_addr[N_CH*ADDR_W] (channel i at [i*ADDR_W +: ADDR_W]),
//          ready[N_CH] (returned by the arbiter).
//
//   Handshake: a request on channel i is transferred in exactly the cycle
//   where req_valid[i] and ready[i] are both high. ready is combinational,
//   one-hot or zero, and depends only on the current request inputs and the
//   arbiter state; a requester must not make req_valid depend on ready.
interface l2_input_arbiter_param_if #(
   parameter int N_CH   = 5,
   parameter int ADDR_W = 32
);
   logic                     decode_en;
   logic [N_CH-1:0]          req_valid;
   logic [N_CH-1:0]          req_elig;
   logic [N_CH*ADDR_W-1:0]   req_addr;
   logic [N_CH-1:0]          ready;

   modport master (output decode_en, req_valid, req_elig, req_addr, input ready);
   modport slave  (input  decode_en, req_valid, req_elig, req_addr, output ready);
endinterface

// File: rtl/l2_arb_age_ctr.sv
// l2_arb_age_ctr
//   Saturating starvation counter for one channel.
//   Ports: clk, rst (sync, active-high), en (decode cycle), cand (channel
//   competed), won (channel granted), starved (age reached STARVE_LIMIT).
module l2_arb_age_ctr
   import l2_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic cand,
   input  logic won,
   output logic starved
);
   localparam int AW = age_w(STARVE_LIMIT);
   localparam logic [AW-1:0] LIMIT = AW'(STARVE_LIMIT);

   logic [AW-1:0] age_q;
   logic [AW-1:0] age_d;

   // Only a losing candidate ages; winning or dropping out resets the count.
   always_comb begin
      age_d = age_q;
      if (en) begin
         if (!cand || won) begin
            age_d = '0;
         end else if (age_q != LIMIT) begin
            age_d = age_q + AW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         age_q <= '0;
      end else begin
         age_q <= age_d;
      end
   end

   assign starved = (age_q == LIMIT);

endmodule

// File: rtl/l2_input_arbiter_param.sv
// l2_input_arbiter_param
//   Fixed-priority arbiter over N_CH L2 input channels with starvation
//   promotion and MSHR credit gating.
//   Ports: clk, rst (sync, active-high); req_if (slave: decode_en,
//   req_valid, req_elig, req_addr in; ready out, combinational one-hot);
//   mshr_free (one MSHR released); registered decode results grant_q,
//   grant_idx_q, grant_valid_q, promoted_q, tag_q, set_q, line_addr_q;
//   credit_cnt (free MSHRs); credit_err (sticky over-release).
module l2_input_arbiter_param
   import l2_arb_pkg::*;
#(
   parameter int              N_CH         = N_CH_DEF,
   parameter int              ADDR_W       = 32,
   parameter int              OFFSET_BITS  = 4,
   parameter int              SET_BITS     = 9,
   parameter int              MSHR_DEPTH   = MSHR_DEPTH_DEF,
   parameter logic [N_CH-1:0] CREDIT_MASK  = CREDIT_MASK_DEF,
   parameter int              STARVE_LIMIT = STARVE_LIMIT_DEF,
   localparam int             IDX_W        = $clog2(N_CH),
   localparam int             TAG_W        = ADDR_W - OFFSET_BITS - SET_BITS,
   localparam int             LINE_W       = ADDR_W - OFFSET_BITS,
   localparam int             CW           = cnt_w(MSHR_DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst,
   l2_input_arbiter_param_if.slave req_if,
   input  logic                   mshr_free,
   output logic [N_CH-1:0]        grant_q,
   output logic [IDX_W-1:0]       grant_idx_q,
   output logic                   grant_valid_q,
   output logic                   promoted_q,
   output logic [TAG_W-1:0]       tag_q,
   output logic [SET_BITS-1:0]    set_q,
   output logic [LINE_W-1:0]      line_addr_q,
   output logic [CW-1:0]          credit_cnt,
   output logic                   credit_err
);
   localparam logic [CW-1:0] CNT_MAX = CW'(MSHR_DEPTH);

   logic [N_CH-1:0]     cand, starved, pick, win_oh;
   logic [IDX_W-1:0]    win_idx;
   logic                win_found, promoted, dec, credit_ok;
   logic [ADDR_W-1:0]   win_addr;
   logic                unused_offset;

   logic [N_CH-1:0]     grant_d;
   logic [IDX_W-1:0]    grant_idx_d;
   logic                grant_valid_d, promoted_d;
   logic [TAG_W-1:0]    tag_d;
   logic [SET_BITS-1:0] set_d;
   logic [LINE_W-1:0]   line_addr_d;
   logic [CW-1:0]       credit_cnt_q, credit_cnt_d;
   logic                credit_err_q, credit_err_d;

   // Credit-consuming channels drop out entirely while no MSHR is free.
   assign credit_ok = (credit_cnt_q != '0);
   assign cand = req_if.req_valid & req_if.req_elig & ~(CREDIT_MASK & {N_CH{!credit_ok}});

   // Starved candidates, when present, replace the full candidate set, so
   // the same lowest-index search serves both the promoted and normal case.
   always_comb begin
      promoted  = |(cand & starved);
      pick      = promoted ? (cand & starved) : cand;
      win_found = |pick;
      win_idx   = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (pick[i]) win_idx = IDX_W'(i);
      end
      win_oh = '0;
      for (int i = 0; i < N_CH; i++) begin
         win_oh[i] = win_found && (win_idx == IDX_W'(i));
      end
   end

   assign win_addr      = req_if.req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
   assign unused_offset = ^win_addr[OFFSET_BITS-1:0];
   assign req_if.ready  = (req_if.decode_en && !rst) ? win_oh : '0;

   for (genvar g = 0; g < N_CH; g++) begin : g_age
      l2_arb_age_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_age (
         .clk     (clk),
         .rst     (rst),
         .en      (req_if.decode_en),
         .cand    (cand[g]),
         .won     (win_oh[g]),
         .starved (starved[g])
      );
   end

   always_comb begin
      grant_d       = grant_q;
      grant_idx_d   = grant_idx_q;
      grant_valid_d = grant_valid_q;
      promoted_d    = promoted_q;
      tag_d         = tag_q;
      set_d         = set_q;
      line_addr_d   = line_addr_q;
      if (req_if.decode_en) begin
         grant_d       = win_oh;
         grant_idx_d   = win_found ? win_idx : '0;
         grant_valid_d = win_found;
         promoted_d    = promoted;
         tag_d         = win_found ? win_addr[ADDR_W-1 -: TAG_W] : '0;
         set_d         = win_found ? win_addr[OFFSET_BITS +: SET_BITS] : '0;
         line_addr_d   = win_found ? win_addr[ADDR_W-1:OFFSET_BITS] : '0;
      end
   end

   // A grant and a release in the same cycle cancel out.
   always_comb begin
      dec          = req_if.decode_en && win_found && CREDIT_MASK[win_idx];
      credit_cnt_d = credit_cnt_q;
      credit_err_d = credit_err_q;
      case ({dec, mshr_free})
         2'b10: credit_cnt_d = credit_cnt_q - CW'(1);
         2'b01: begin
            if (credit_cnt_q == CNT_MAX) credit_err_d = 1'b1;
            else                         credit_cnt_d = credit_cnt_q + CW'(1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         grant_q       <= '0;
         grant_idx_q   <= '0;
         grant_valid_q <= 1'b0;
         promoted_q    <= 1'b0;
         tag_q         <= '0;
         set_q         <= '0;
         line_addr_q   <= '0;
         credit_cnt_q  <= CNT_MAX;
         credit_err_q  <= 1'b0;
      end else begin
         grant_q       <= grant_d;
         grant_idx_q   <= grant_idx_d;
         grant_valid_q <= grant_valid_d;
         promoted_q    <= promoted_d;
         tag_q         <= tag_d;
         set_q         <= set_d;
         line_addr_q   <= line_addr_d;
         credit_cnt_q  <= credit_cnt_d;
         credit_err_q  <= credit_err_d;
      end
   end

   assign credit_cnt = credit_cnt_q;
   assign credit_err = credit_err_q;

endmodule
